// File: rtl/timer_arbiter_if.sv
// Handshake bundle between requesters and the shared down-counting timer.
// The master side drives requests and load values; the slave side is the arbiter.
interface timer_arbiter_if #(parameter int dw = 8);
    logic [1:0]    req;
    logic [dw-1:0] load0;
    logic [dw-1:0] load1;
    logic          pause;
    logic [1:0]    grant;
    logic [1:0]    done;
    logic          busy;
    logic [dw-1:0] count;

    modport master (
        output req, load0, load1, pause,
        input  grant, done, busy, count
    );

    modport slave (
        input  req, load0, load1, pause,
        output grant, done, busy, count
    );
endinterface

// File: rtl/timer_arbiter.sv
// Two-requester round-robin arbiter owning one shared down-counter.
// The owner keeps req high for the whole job; dropping it aborts without a done pulse.
module timer_arbiter #(
    parameter int dw = 8
) (
    input  logic          clk,
    input  logic          reset,
    timer_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t        state, stateNext;
    logic [1:0]    grant, grantNext;
    logic [1:0]    done, doneNext;
    logic [dw-1:0] count, countNext;
    logic          last, lastNext;
    logic          pick;
    logic          owner;

    assign owner     = grant[1];
    assign bus.grant = grant;
    assign bus.done  = done;
    assign bus.count = count;
    assign bus.busy  = (state != IDLE);

    // last resets to 1 so that requester 0 wins the first tie
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            grant <= '0;
            done  <= '0;
            count <= '0;
            last  <= 1'b1;
        end else begin
            state <= stateNext;
            grant <= grantNext;
            done  <= doneNext;
            count <= countNext;
            last  <= lastNext;
        end
    end

    always_comb begin
        stateNext = state;
        grantNext = grant;
        doneNext  = '0;
        countNext = count;
        lastNext  = last;
        pick      = 1'b0;

        case (state)
            IDLE: begin
                grantNext = '0;
                if (bus.req != 2'b00) begin
                    pick      = (bus.req == 2'b11) ? ~last : bus.req[1];
                    stateNext = COUNT;
                    grantNext = pick ? 2'b10 : 2'b01;
                    countNext = pick ? bus.load1 : bus.load0;
                    lastNext  = pick;
                end
            end

            // abort outranks pause, and zero is reached without ever wrapping
            COUNT: begin
                if (!bus.req[owner]) begin
                    stateNext = IDLE;
                    grantNext = '0;
                    countNext = '0;
                end else if (bus.pause) begin
                    countNext = count;
                end else if (count == '0) begin
                    stateNext = DONE;
                    doneNext  = grant;
                end else begin
                    countNext = count - dw'(1);
                end
            end

            DONE: begin
                stateNext = IDLE;
                grantNext = '0;
                countNext = '0;
            end

            default: begin
                stateNext = IDLE;
                grantNext = '0;
                countNext = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_timer_arbiter.sv
// Directed, table-driven bench for timer_arbiter plus hand-written sequences
// for the full-width count and the asynchronous reset.
module tb_timer_arbiter;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    timer_arbiter_if #(.dw(8)) bus ();

    timer_arbiter #(.dw(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [1:0] req;
        logic [7:0] load0;
        logic [7:0] load1;
        logic       pause;
        logic [1:0] expGrant;
        logic [1:0] expDone;
        logic       expBusy;
        logic [7:0] expCount;
    } vec_t;

    vec_t vecs[$];

    task automatic addVec(input string name, input logic [1:0] req, input logic [7:0] l0,
                          input logic [7:0] l1, input logic pause, input logic [1:0] g,
                          input logic [1:0] d, input logic b, input logic [7:0] c);
        vec_t v;
        v.name = name; v.req = req; v.load0 = l0; v.load1 = l1; v.pause = pause;
        v.expGrant = g; v.expDone = d; v.expBusy = b; v.expCount = c;
        vecs.push_back(v);
    endtask

    task automatic applyStimulus(input logic [1:0] req, input logic [7:0] l0,
                                 input logic [7:0] l1, input logic pause);
        bus.req   = req;
        bus.load0 = l0;
        bus.load1 = l1;
        bus.pause = pause;
    endtask

    task automatic checkOutput(input string name, input logic [1:0] expGrant,
                               input logic [1:0] expDone, input logic expBusy,
                               input logic [7:0] expCount);
        checks++;
        if (bus.grant !== expGrant) begin
            errors++;
            $display("[TB] FAIL %s grant: got %b expected %b", name, bus.grant, expGrant);
        end
        checks++;
        if (bus.done !== expDone) begin
            errors++;
            $display("[TB] FAIL %s done: got %b expected %b", name, bus.done, expDone);
        end
        checks++;
        if (bus.busy !== expBusy) begin
            errors++;
            $display("[TB] FAIL %s busy: got %b expected %b", name, bus.busy, expBusy);
        end
        checks++;
        if (bus.count !== expCount) begin
            errors++;
            $display("[TB] FAIL %s count: got %0d expected %0d", name, bus.count, expCount);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset  = 1'b0;
        applyStimulus(2'b00, 8'd0, 8'd0, 1'b0);

        // tie after reset goes to 0, then alternates; final 0-grant is aborted
        addVec("tie_g0",    2'b11, 8'd2, 8'd1, 1'b0, 2'b01, 2'b00, 1'b1, 8'd2);
        addVec("tie_c1",    2'b11, 8'd2, 8'd1, 1'b0, 2'b01, 2'b00, 1'b1, 8'd1);
        addVec("tie_c0",    2'b11, 8'd2, 8'd1, 1'b0, 2'b01, 2'b00, 1'b1, 8'd0);
        addVec("tie_d0",    2'b11, 8'd2, 8'd1, 1'b0, 2'b01, 2'b01, 1'b1, 8'd0);
        addVec("tie_idle",  2'b11, 8'd2, 8'd1, 1'b0, 2'b00, 2'b00, 1'b0, 8'd0);
        addVec("tie_g1",    2'b11, 8'd2, 8'd1, 1'b0, 2'b10, 2'b00, 1'b1, 8'd1);
        addVec("tie_c1b",   2'b11, 8'd2, 8'd1, 1'b0, 2'b10, 2'b00, 1'b1, 8'd0);
        addVec("tie_d1",    2'b11, 8'd2, 8'd1, 1'b0, 2'b10, 2'b10, 1'b1, 8'd0);
        addVec("tie_idle2", 2'b11, 8'd2, 8'd1, 1'b0, 2'b00, 2'b00, 1'b0, 8'd0);
        addVec("tie_g0b",   2'b11, 8'd2, 8'd1, 1'b0, 2'b01, 2'b00, 1'b1, 8'd2);
        addVec("abort0",    2'b00, 8'd2, 8'd1, 1'b0, 2'b00, 2'b00, 1'b0, 8'd0);
        // single job, load 3
        addVec("job_g",     2'b01, 8'd3, 8'd9, 1'b0, 2'b01, 2'b00, 1'b1, 8'd3);
        addVec("job_c2",    2'b01, 8'd3, 8'd9, 1'b0, 2'b01, 2'b00, 1'b1, 8'd2);
        addVec("job_c1",    2'b01, 8'd3, 8'd9, 1'b0, 2'b01, 2'b00, 1'b1, 8'd1);
        addVec("job_c0",    2'b01, 8'd3, 8'd9, 1'b0, 2'b01, 2'b00, 1'b1, 8'd0);
        addVec("job_done",  2'b01, 8'd3, 8'd9, 1'b0, 2'b01, 2'b01, 1'b1, 8'd0);
        addVec("job_idle",  2'b00, 8'd3, 8'd9, 1'b0, 2'b00, 2'b00, 1'b0, 8'd0);
        addVec("idle_hold", 2'b00, 8'd7, 8'd7, 1'b1, 2'b00, 2'b00, 1'b0, 8'd0);
        // pause for 3 cycles right after the grant
        addVec("pz_g",      2'b01, 8'd2, 8'd0, 1'b0, 2'b01, 2'b00, 1'b1, 8'd2);
        addVec("pz_h1",     2'b01, 8'd2, 8'd0, 1'b1, 2'b01, 2'b00, 1'b1, 8'd2);
        addVec("pz_h2",     2'b01, 8'd2, 8'd0, 1'b1, 2'b01, 2'b00, 1'b1, 8'd2);
        addVec("pz_h3",     2'b01, 8'd2, 8'd0, 1'b1, 2'b01, 2'b00, 1'b1, 8'd2);
        addVec("pz_c1",     2'b01, 8'd2, 8'd0, 1'b0, 2'b01, 2'b00, 1'b1, 8'd1);
        addVec("pz_c0",     2'b01, 8'd2, 8'd0, 1'b0, 2'b01, 2'b00, 1'b1, 8'd0);
        addVec("pz_done",   2'b01, 8'd2, 8'd0, 1'b0, 2'b01, 2'b01, 1'b1, 8'd0);
        addVec("pz_idle",   2'b00, 8'd2, 8'd0, 1'b0, 2'b00, 2'b00, 1'b0, 8'd0);
        // requester 1 aborts at count 3 while pause is also high
        addVec("ab_g",      2'b10, 8'd0, 8'd5, 1'b0, 2'b10, 2'b00, 1'b1, 8'd5);
        addVec("ab_c4",     2'b10, 8'd0, 8'd5, 1'b0, 2'b10, 2'b00, 1'b1, 8'd4);
        addVec("ab_c3",     2'b10, 8'd0, 8'd5, 1'b0, 2'b10, 2'b00, 1'b1, 8'd3);
        addVec("ab_drop",   2'b00, 8'd0, 8'd5, 1'b1, 2'b00, 2'b00, 1'b0, 8'd0);
        addVec("ab_idle",   2'b00, 8'd0, 8'd5, 1'b0, 2'b00, 2'b00, 1'b0, 8'd0);
        // zero load completes one edge after the grant
        addVec("z_g",       2'b01, 8'd0, 8'd4, 1'b0, 2'b01, 2'b00, 1'b1, 8'd0);
        addVec("z_done",    2'b01, 8'd0, 8'd4, 1'b0, 2'b01, 2'b01, 1'b1, 8'd0);
        addVec("z_idle",    2'b00, 8'd0, 8'd4, 1'b0, 2'b00, 2'b00, 1'b0, 8'd0);

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset", 2'b00, 2'b00, 1'b0, 8'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("post_reset_idle", 2'b00, 2'b00, 1'b0, 8'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].req, vecs[i].load0, vecs[i].load1, vecs[i].pause);
            @(posedge clk);
            #1;
            checkOutput(vecs[i].name, vecs[i].expGrant, vecs[i].expDone,
                        vecs[i].expBusy, vecs[i].expCount);
        end

        // all-ones load: 255 decrements to zero, then DONE at E0+256
        applyStimulus(2'b01, 8'd255, 8'd0, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("full_g", 2'b01, 2'b00, 1'b1, 8'd255);
        for (int k = 1; k <= 255; k++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("full_c%0d", k), 2'b01, 2'b00, 1'b1, 8'(255 - k));
        end
        @(posedge clk);
        #1;
        checkOutput("full_done", 2'b01, 2'b01, 1'b1, 8'd0);
        applyStimulus(2'b00, 8'd0, 8'd0, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("full_idle", 2'b00, 2'b00, 1'b0, 8'd0);

        // async reset mid-count; afterwards requester 0 must win the tie again
        applyStimulus(2'b01, 8'd5, 8'd6, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("rst_job_g", 2'b01, 2'b00, 1'b1, 8'd5);
        @(posedge clk);
        #1;
        checkOutput("rst_job_c4", 2'b01, 2'b00, 1'b1, 8'd4);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("rst_async", 2'b00, 2'b00, 1'b0, 8'd0);
        @(posedge clk);
        #1;
        checkOutput("rst_held", 2'b00, 2'b00, 1'b0, 8'd0);
        applyStimulus(2'b11, 8'd7, 8'd6, 1'b0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("rst_tie_g0", 2'b01, 2'b00, 1'b1, 8'd7);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
